irq_controller: RTL and testbench
=================================

Name: irq_controller

Overview:
- Collects single-bit event lines from timer instances and other peripherals, and latches each rising edge as a pending interrupt.
- Presents one interrupt at a time to the Forth CPU core as a request plus a binary vector.
- Retires the interrupt through a four-phase irq/ack handshake.
- Sits between the peripheral event lines and the CPU's interrupt entry logic. It consumes the event line that the timer produces.

Parameters:
- SOURCES, 8: number of event input lines (1..32).
- VEC_BITS, 3: width of the vector output; must satisfy 2**VEC_BITS >= SOURCES.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- enable  input  1  global interrupt enable from the CPU; 0 suppresses new requests.
- src  input  SOURCES  event lines, synchronous to clock (e.g. timer line outputs).
- mask_we  input  1  write strobe for the mask register.
- mask_wdata  input  SOURCES  new mask value; bit = 1 means the source is allowed.
- mask  output  SOURCES  current mask register.
- pending  output  SOURCES  current pending register.
- irq  output  1  interrupt request to the CPU.
- vector  output  VEC_BITS  index of the source being requested; valid while irq = 1.
- ack  input  1  CPU acknowledge (four-phase).

Behaviour:
- Reset (reset = 0, asynchronous):
  - src_q, pending, mask, vector = 0; irq = 0; state = IDLE.
  - Applies immediately, including mid-handshake; the in-flight interrupt is lost.
- Edge detect:
  - src_q <= src every cycle.
  - rise[i] = src[i] & ~src_q[i].
  - A level held high produces exactly one rise. The first cycle after reset release with src already high counts as a rise.
- Pending:
  - pending[i] <= 1 on rise[i], independent of mask and enable.
  - Cleared only by retirement (see REQ).
  - If a rise and a retirement hit the same bit in the same cycle, the set wins and the bit stays 1.
- Mask:
  - mask <= mask_wdata when mask_we = 1; takes effect for arbitration on the next cycle.
  - Masking a source never clears its pending bit.
- Arbitration:
  - eligible = pending & mask.
  - Winner = lowest set index of eligible (fixed priority; index 0 is highest).
- FSM, state IDLE:
  - irq = 0.
  - If enable = 1 and eligible != 0: vector <= winner, irq <= 1, go to REQ.
  - ack is ignored in IDLE.
- FSM, state REQ:
  - irq = 1; vector is held stable regardless of later mask/enable changes or new pending bits. The request is never withdrawn.
  - On ack = 1: pending[vector] <= 0 (subject to the set-wins rule), irq <= 0, go to WAIT_REL.
- FSM, state WAIT_REL:
  - irq = 0.
  - When ack = 0, go to IDLE.
  - A stuck-high ack holds the FSM here; no new request is issued.
- Latency:
  - src rises before clock edge N → pending set at edge N → irq = 1 after edge N+1 (two cycles), when in IDLE with enable = 1 and the source unmasked.
  - Back-to-back: ack drops at edge M → IDLE at M → next irq at M+1 at the earliest.
- enable = 0 in REQ or WAIT_REL: no effect on the current handshake; only blocks the IDLE→REQ transition.
- Vector width: winner is zero-extended into VEC_BITS. Indices >= SOURCES never occur.

Decomposition:
- Package forth_irq_pkg holds:
  - FSM state encoding: IDLE = 2'd0, REQ = 2'd1, WAIT_REL = 2'd2.
  - Default SOURCES and VEC_BITS constants.
- One combinational sub-module, irq_priority_enc:
  - Input: eligible vector.
  - Outputs: any (1 bit) and index (VEC_BITS), lowest-index-first.
  - Reused by later multi-level controllers.
- All sequential logic stays in irq_controller.

Test Plan:
1. Reset, then mask_we with mask_wdata = 8'hFF. Pulse src[3] for one cycle → pending = 8'h08 after one edge; irq = 1, vector = 3 one edge later. Raise ack → irq = 0, pending = 0. Drop ack → back in IDLE.
2. With mask = 8'hFF, set src[5] and src[2] in the same cycle → vector = 2 first. After the ack cycle completes, irq reasserts with vector = 5.
3. With mask = 8'h00, pulse src[1] → pending = 8'h02, irq stays 0. Write mask = 8'h02 → irq = 1, vector = 1 two edges after the write strobe.
4. In REQ with vector = 4, pulse src[4] in the same cycle as ack rises → irq drops and pending[4] remains 1. After ack falls, irq reasserts with vector = 4.
5. With enable = 0 and pulses on src[0] and src[7] → pending = 8'h81, irq = 0. Raise enable → vector = 0 then vector = 7 in successive handshakes.
6. Drive reset = 0 asynchronously mid-REQ (between clock edges) → irq, vector, pending, mask read 0 before the next edge. src held high across reset release → one new pending bit only.

Source files
------------

// File: rtl/forth_irq_pkg.sv
// Shared definitions for the Forth CPU interrupt controller family:
// handshake FSM encoding and default sizing.
package forth_irq_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_REL = 2'd2
    } irq_state_t;

    localparam int DEF_SOURCES  = 8;
    localparam int DEF_VEC_BITS = 3;

endpackage

// File: rtl/irq_priority_enc.sv
// Fixed-priority encoder: reports whether any input bit is set and the
// index of the lowest set bit (index 0 has the highest priority).
module irq_priority_enc
    import forth_irq_pkg::*;
#(
    parameter int SOURCES  = DEF_SOURCES,
    parameter int VEC_BITS = DEF_VEC_BITS
) (
    input  logic [SOURCES-1:0]  eligible,
    output logic                any,
    output logic [VEC_BITS-1:0] index
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        any   = 1'b0;
        index = '0;
        for (int i = SOURCES - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                any   = 1'b1;
                index = i[VEC_BITS-1:0];
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: latches rising edges of peripheral event lines as
// pending interrupts and presents them one at a time to the CPU through a
// four-phase irq/ack handshake.
module irq_controller
    import forth_irq_pkg::*;
#(
    parameter int SOURCES  = DEF_SOURCES,
    parameter int VEC_BITS = DEF_VEC_BITS
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic [SOURCES-1:0]  src,
    input  logic                mask_we,
    input  logic [SOURCES-1:0]  mask_wdata,
    output logic [SOURCES-1:0]  mask,
    output logic [SOURCES-1:0]  pending,
    output logic                irq,
    output logic [VEC_BITS-1:0] vector,
    input  logic                ack
);

    logic [SOURCES-1:0]  src_q, src_d;
    logic [SOURCES-1:0]  pending_q, pending_d;
    logic [SOURCES-1:0]  mask_q, mask_d;
    logic [SOURCES-1:0]  rise;
    logic [SOURCES-1:0]  eligible;
    logic [SOURCES-1:0]  retire;
    irq_state_t          state_q, state_d;
    logic                irq_q, irq_d;
    logic [VEC_BITS-1:0] vector_q, vector_d;
    logic                win_any;
    logic [VEC_BITS-1:0] win_idx;

    // src_q is cleared by reset, so a line already high at release counts as a rise.
    assign rise     = src & ~src_q;
    assign eligible = pending_q & mask_q;

    irq_priority_enc #(
        .SOURCES  (SOURCES),
        .VEC_BITS (VEC_BITS)
    ) u_prio (
        .eligible (eligible),
        .any      (win_any),
        .index    (win_idx)
    );

    // One-hot clear of the interrupt being acknowledged.
    always_comb begin
        retire = '0;
        if (state_q == REQ && ack) begin
            for (int i = 0; i < SOURCES; i++) begin
                if (vector_q == i[VEC_BITS-1:0]) begin
                    retire[i] = 1'b1;
                end
            end
        end
    end

    // Edge history, mask write and pending update; a new rise beats a retirement.
    always_comb begin
        src_d     = src;
        mask_d    = mask_we ? mask_wdata : mask_q;
        pending_d = (pending_q & ~retire) | rise;
    end

    // Handshake FSM: pick a winner in IDLE, hold it through REQ, wait for ack release.
    always_comb begin
        state_d  = state_q;
        irq_d    = irq_q;
        vector_d = vector_q;
        case (state_q)
            IDLE: begin
                irq_d = 1'b0;
                if (enable && win_any) begin
                    vector_d = win_idx;
                    irq_d    = 1'b1;
                    state_d  = REQ;
                end
            end
            REQ: begin
                irq_d = 1'b1;
                if (ack) begin
                    irq_d   = 1'b0;
                    state_d = WAIT_REL;
                end
            end
            WAIT_REL: begin
                irq_d = 1'b0;
                if (!ack) begin
                    state_d = IDLE;
                end
            end
            default: begin
                irq_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // Handshake state, request and vector registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            irq_q    <= 1'b0;
            vector_q <= '0;
        end else begin
            state_q  <= state_d;
            irq_q    <= irq_d;
            vector_q <= vector_d;
        end
    end

    // Edge history, pending and mask registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            src_q     <= '0;
            pending_q <= '0;
            mask_q    <= '0;
        end else begin
            src_q     <= src_d;
            pending_q <= pending_d;
            mask_q    <= mask_d;
        end
    end

    assign mask    = mask_q;
    assign pending = pending_q;
    assign irq     = irq_q;
    assign vector  = vector_q;

endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: a table of per-cycle input/expected-output
// records plus a hand-written asynchronous reset sequence; expectations go
// through a scoreboard queue and are compared one cycle after being driven.
module tb_irq_controller;

    logic       clock;
    logic       reset;
    logic       enable;
    logic [7:0] src;
    logic       mask_we;
    logic [7:0] mask_wdata;
    logic [7:0] mask;
    logic [7:0] pending;
    logic       irq;
    logic [2:0] vector;
    logic       ack;

    irq_controller #(
        .SOURCES  (8),
        .VEC_BITS (3)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .src        (src),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .mask       (mask),
        .pending    (pending),
        .irq        (irq),
        .vector     (vector),
        .ack        (ack)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       en;
        logic [7:0] src;
        logic       we;
        logic [7:0] wd;
        logic       ack;
        logic       irq;
        logic [2:0] vec;
        logic [7:0] pend;
        logic [7:0] mask;
    } vec_t;

    typedef struct {
        int         id;
        logic       irq;
        logic [2:0] vec;
        logic [7:0] pend;
        logic [7:0] mask;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(input logic en, input logic [7:0] s, input logic we,
                                input logic [7:0] wd, input logic a, input logic ei,
                                input logic [2:0] ev, input logic [7:0] ep,
                                input logic [7:0] em);
        vec_t v;
        v.en = en; v.src = s; v.we = we; v.wd = wd; v.ack = a;
        v.irq = ei; v.vec = ev; v.pend = ep; v.mask = em;
        return v;
    endfunction

    // Pop the oldest expectation and compare; vector only matters while irq = 1.
    task automatic check_next();
        exp_t e;
        if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard_empty: got 0 entries, want at least 1");
            return;
        end
        e = sb.pop_front();
        n_vec++;
        if (irq !== e.irq || pending !== e.pend || mask !== e.mask ||
            (e.irq && vector !== e.vec)) begin
            n_err++;
            $display("FAIL vec%0d: got irq=%b vec=%0d pend=%h mask=%h, want irq=%b vec=%0d pend=%h mask=%h",
                     e.id, irq, vector, pending, mask, e.irq, e.vec, e.pend, e.mask);
        end
    endtask

    task automatic push_exp(input int id, input logic ei, input logic [2:0] ev,
                            input logic [7:0] ep, input logic [7:0] em);
        exp_t e;
        e.id = id; e.irq = ei; e.vec = ev; e.pend = ep; e.mask = em;
        sb.push_back(e);
    endtask

    task automatic apply(input int id, input vec_t v);
        @(negedge clock);
        enable     = v.en;
        src        = v.src;
        mask_we    = v.we;
        mask_wdata = v.wd;
        ack        = v.ack;
        push_exp(id, v.irq, v.vec, v.pend, v.mask);
        @(posedge clock);
        #1;
        check_next();
    endtask

    initial begin
        //            en  src    we  wd     ack irq vec pend   mask
        // single source, full handshake
        tbl.push_back(mk(1, 8'h00, 1, 8'hFF, 0, 0, 0, 8'h00, 8'hFF));
        tbl.push_back(mk(1, 8'h08, 0, 8'h00, 0, 0, 0, 8'h08, 8'hFF));
        tbl.push_back(mk(1, 8'h00, 0, 8'h00, 0, 1, 3, 8'h08, 8'hFF));
        tbl.push_back(mk(1, 8'h00, 0, 8'h00, 1, 0, 0, 8'h00, 8'hFF));
        tbl.push_back(mk(1, 8'h00, 0, 8'h00, 0, 0, 0, 8'h00, 8'hFF));
        tbl.push_back(mk(1, 8'h00, 0, 8'h00, 0, 0, 0, 8'h00, 8'hFF));
        // two simultaneous sources: lowest index first
        tbl.push_back(mk(1, 8'h24, 0, 8'h00, 0, 0, 0, 8'h24, 8'hFF));
        tbl.push_back(mk(1, 8'h00, 0, 8'h00, 0, 1, 2, 8'h24, 8'hFF));
        tbl.push_back(mk(1, 8'h00, 0, 8'h00, 1, 0, 0, 8'h20, 8'hFF));
        tbl.push_back(mk(1, 8'h00, 0, 8'h00, 0, 0, 0, 8'h20, 8'hFF));
        tbl.push_back(mk(1, 8'h00, 0, 8'h00, 0, 1, 5, 8'h20, 8'hFF));
        tbl.push_back(mk(1, 8'h00, 0, 8'h00, 1, 0, 0, 8'h00, 8'hFF));
        tbl.push_back(mk(1, 8'h00, 0, 8'h00, 0, 0, 0, 8'h00, 8'hFF));
        // masked source stays pending, unmasking releases it
        tbl.push_back(mk(1, 8'h00, 1, 8'h00, 0, 0, 0, 8'h00, 8'h00));
        tbl.push_back(mk(1, 8'h02, 0, 8'h00, 0, 0, 0, 8'h02, 8'h00));
        tbl.push_back(mk(1, 8'h00, 0, 8'h00, 0, 0, 0, 8'h02, 8'h00));
        tbl.push_back(mk(1, 8'h00, 0, 8'h00, 0, 0, 0, 8'h02, 8'h00));
        tbl.push_back(mk(1, 8'h00, 1, 8'h02, 0, 0, 0, 8'h02, 8'h02));
        tbl.push_back(mk(1, 8'h00, 0, 8'h00, 0, 1, 1, 8'h02, 8'h02));
        tbl.push_back(mk(1, 8'h00, 0, 8'h00, 1, 0, 0, 8'h00, 8'h02));
        tbl.push_back(mk(1, 8'h00, 0, 8'h00, 0, 0, 0, 8'h00, 8'h02));
        // rise coincident with ack: set wins; stuck ack holds off re-request
        tbl.push_back(mk(1, 8'h10, 1, 8'hFF, 0, 0, 0, 8'h10, 8'hFF));
        tbl.push_back(mk(1, 8'h00, 0, 8'h00, 0, 1, 4, 8'h10, 8'hFF));
        tbl.push_back(mk(1, 8'h10, 0, 8'h00, 1, 0, 0, 8'h10, 8'hFF));
        tbl.push_back(mk(1, 8'h00, 0, 8'h00, 1, 0, 0, 8'h10, 8'hFF));
        tbl.push_back(mk(1, 8'h00, 0, 8'h00, 1, 0, 0, 8'h10, 8'hFF));
        tbl.push_back(mk(1, 8'h00, 0, 8'h00, 0, 0, 0, 8'h10, 8'hFF));
        tbl.push_back(mk(1, 8'h00, 0, 8'h00, 0, 1, 4, 8'h10, 8'hFF));
        tbl.push_back(mk(1, 8'h00, 0, 8'h00, 1, 0, 0, 8'h00, 8'hFF));
        tbl.push_back(mk(1, 8'h00, 0, 8'h00, 0, 0, 0, 8'h00, 8'hFF));
        // global enable gating; enable drop in REQ does not withdraw
        tbl.push_back(mk(0, 8'h81, 0, 8'h00, 0, 0, 0, 8'h81, 8'hFF));
        tbl.push_back(mk(0, 8'h00, 0, 8'h00, 0, 0, 0, 8'h81, 8'hFF));
        tbl.push_back(mk(0, 8'h00, 0, 8'h00, 0, 0, 0, 8'h81, 8'hFF));
        tbl.push_back(mk(1, 8'h00, 0, 8'h00, 0, 1, 0, 8'h81, 8'hFF));
        tbl.push_back(mk(1, 8'h00, 0, 8'h00, 1, 0, 0, 8'h80, 8'hFF));
        tbl.push_back(mk(1, 8'h00, 0, 8'h00, 0, 0, 0, 8'h80, 8'hFF));
        tbl.push_back(mk(1, 8'h00, 0, 8'h00, 0, 1, 7, 8'h80, 8'hFF));
        tbl.push_back(mk(0, 8'h01, 0, 8'h00, 0, 1, 7, 8'h81, 8'hFF));
        tbl.push_back(mk(0, 8'h00, 0, 8'h00, 1, 0, 0, 8'h01, 8'hFF));
        tbl.push_back(mk(0, 8'h00, 0, 8'h00, 0, 0, 0, 8'h01, 8'hFF));
        tbl.push_back(mk(0, 8'h00, 0, 8'h00, 0, 0, 0, 8'h01, 8'hFF));
        // enter REQ on source 0 ahead of the asynchronous reset sequence
        tbl.push_back(mk(1, 8'h00, 0, 8'h00, 0, 1, 0, 8'h01, 8'hFF));

        reset      = 1'b0;
        enable     = 1'b0;
        src        = '0;
        mask_we    = 1'b0;
        mask_wdata = '0;
        ack        = 1'b0;

        // reset state
        #12;
        push_exp(-1, 0, 0, 8'h00, 8'h00);
        check_next();
        if (vector !== 3'd0) begin
            n_err++;
            $display("FAIL reset_vector: got %0d, want 0", vector);
        end
        n_vec++;
        @(negedge clock);
        reset = 1'b1;

        foreach (tbl[i]) apply(i, tbl[i]);

        // asynchronous reset mid-REQ, with src[2] rising and held across release
        @(negedge clock);
        src = 8'h04;
        #2;
        reset = 1'b0;
        #1;
        push_exp(100, 0, 0, 8'h00, 8'h00);
        check_next();
        if (vector !== 3'd0) begin
            n_err++;
            $display("FAIL async_reset_vector: got %0d, want 0", vector);
        end
        n_vec++;
        @(posedge clock);
        #1;
        push_exp(101, 0, 0, 8'h00, 8'h00);
        check_next();
        @(negedge clock);
        reset = 1'b1;
        push_exp(102, 0, 0, 8'h04, 8'h00);
        @(posedge clock);
        #1;
        check_next();
        push_exp(103, 0, 0, 8'h04, 8'h00);
        @(posedge clock);
        #1;
        check_next();
        // unmask: the single captured edge is presented, then retired for good
        @(negedge clock);
        mask_we    = 1'b1;
        mask_wdata = 8'hFF;
        push_exp(104, 0, 0, 8'h04, 8'hFF);
        @(posedge clock);
        #1;
        check_next();
        @(negedge clock);
        mask_we = 1'b0;
        push_exp(105, 1, 2, 8'h04, 8'hFF);
        @(posedge clock);
        #1;
        check_next();
        @(negedge clock);
        ack = 1'b1;
        push_exp(106, 0, 0, 8'h00, 8'hFF);
        @(posedge clock);
        #1;
        check_next();
        @(negedge clock);
        ack = 1'b0;
        push_exp(107, 0, 0, 8'h00, 8'hFF);
        @(posedge clock);
        #1;
        check_next();
        push_exp(108, 0, 0, 8'h00, 8'hFF);
        @(posedge clock);
        #1;
        check_next();

        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard_leftover: got %0d entries, want 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Bound the run in case the stimulus process ever stalls.
    initial begin
        #20000;
        $display("FAIL watchdog: got timeout at %0t, want completion", $time);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
